// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment display path.
//   mode_e      : display mode as presented on the mode input
//   GLY_*       : glyph codes above the hex range (0x00-0x0F are hex digits)
//   SEG_BLANK   : all segments and the decimal point dark (active-low)
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam logic [5:0] GLY_DASH  = 6'h10;
  localparam logic [5:0] GLY_P     = 6'h11;
  localparam logic [5:0] GLY_H     = 6'h12;
  localparam logic [5:0] GLY_L     = 6'h13;
  localparam logic [5:0] GLY_U     = 6'h14;
  localparam logic [5:0] GLY_N     = 6'h15;
  localparam logic [5:0] GLY_BLANK = 6'h3F;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG7_OFF  = 7'h7F;

endpackage

// File: rtl/glyph_to_seg.sv
// glyph_to_seg: combinational glyph decoder, 6-bit code to active-low
// segments [0]=a .. [6]=g. Codes outside the defined set decode to blank.
//   i_code : glyph code
//   o_seg  : active-low segment pattern (no decimal point)
module glyph_to_seg
  import seg_pkg::*;
(
  input  logic [5:0] i_code,
  output logic [6:0] o_seg
);

  // Patterns are written active-high (gfedcba) for readability, then inverted.
  logic [6:0] w_on;

  always_comb begin
    w_on = 7'h00;
    case (i_code)
      6'h00:    w_on = 7'h3F;
      6'h01:    w_on = 7'h06;
      6'h02:    w_on = 7'h5B;
      6'h03:    w_on = 7'h4F;
      6'h04:    w_on = 7'h66;
      6'h05:    w_on = 7'h6D;
      6'h06:    w_on = 7'h7D;
      6'h07:    w_on = 7'h07;
      6'h08:    w_on = 7'h7F;
      6'h09:    w_on = 7'h6F;
      6'h0A:    w_on = 7'h77;
      6'h0B:    w_on = 7'h7C;
      6'h0C:    w_on = 7'h39;
      6'h0D:    w_on = 7'h5E;
      6'h0E:    w_on = 7'h79;
      6'h0F:    w_on = 7'h71;
      GLY_DASH: w_on = 7'h40;
      GLY_P:    w_on = 7'h73;
      GLY_H:    w_on = 7'h76;
      GLY_L:    w_on = 7'h38;
      GLY_U:    w_on = 7'h3E;
      GLY_N:    w_on = 7'h54;
      default:  w_on = 7'h00;
    endcase
  end

  assign o_seg = ~w_on;

endmodule

// File: rtl/seg_scan_engine.sv
// seg_scan_engine: N-digit multiplexed seven-segment scan engine with
// OFF / STATIC / SCROLL / BLINK modes. Mode and buffer contents are sampled
// only at frame boundaries so a frame is never drawn from mixed data.
//   clk, rst    : clock, synchronous active-high reset
//   mode        : requested display mode (seg_pkg::mode_e encoding)
//   glyphs      : glyph codes, digit i at [6i+5:6i]
//   dp_mask     : decimal point per digit (1 = lit)
//   blink_mask  : digits blanked during the blink-off phase
//   dig         : active-low digit enables, at most one low
//   seg         : active-low segments, [7] = decimal point
//   frame_pulse : one-cycle pulse the cycle after each frame end
module seg_scan_engine
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int DIG_TICKS     = 100000,
  parameter int SCROLL_FRAMES = 125,
  parameter int BLINK_FRAMES  = 62
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [6*NUM_DIGITS-1:0] glyphs,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [7:0]              seg,
  output logic                    frame_pulse
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(DIG_TICKS);
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]           r_pcnt;
  logic [IW-1:0]           r_idx;
  logic                    r_frame_pulse;
  mode_e                   r_cur_mode;
  logic [IW-1:0]           r_ofs;
  logic [SW-1:0]           r_scnt;
  logic [BW-1:0]           r_bcnt;
  logic                    r_blink_phase;
  logic [6*NUM_DIGITS-1:0] r_glyph_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_bl_sh;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic [7:0]              r_seg;

  logic                    w_tick;
  logic                    w_frame_end;
  mode_e                   w_mode_in;
  logic [IW:0]             w_sum;
  logic [IW:0]             w_sel_full;
  logic [IW-1:0]           w_sel;
  logic [5:0]              w_glyph_arr [NUM_DIGITS];
  logic [5:0]              w_glyph;
  logic [6:0]              w_seg7;
  logic                    w_blank;

  assign w_tick      = (r_pcnt == PW'(DIG_TICKS - 1));
  assign w_frame_end = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_mode_in   = mode_e'(mode);

  // Marquee rotation: position p shows buffer slot (p + ofs) mod N.
  // Both operands are < N, so one conditional subtract is enough.
  assign w_sum      = {1'b0, r_idx} + {1'b0, r_ofs};
  assign w_sel_full = (w_sum >= (IW+1)'(NUM_DIGITS)) ? w_sum - (IW+1)'(NUM_DIGITS) : w_sum;
  assign w_sel      = w_sel_full[IW-1:0];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph_slice
    assign w_glyph_arr[gi] = r_glyph_sh[6*gi +: 6];
  end

  assign w_glyph = w_glyph_arr[w_sel];

  glyph_to_seg u_decode (
    .i_code (w_glyph),
    .o_seg  (w_seg7)
  );

  // dp and blink bits follow the physical position, not the rotated glyph.
  assign w_blank = (r_cur_mode == MODE_OFF) ||
                   ((r_cur_mode == MODE_BLINK) && r_blink_phase && r_bl_sh[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt        <= '0;
      r_idx         <= '0;
      r_frame_pulse <= 1'b0;
      r_cur_mode    <= MODE_OFF;
      r_ofs         <= '0;
      r_scnt        <= '0;
      r_bcnt        <= '0;
      r_blink_phase <= 1'b0;
      r_glyph_sh    <= '0;
      r_dp_sh       <= '0;
      r_bl_sh       <= '0;
      r_dig         <= '1;
      r_seg         <= SEG_BLANK;
    end else begin
      r_pcnt        <= w_tick ? '0 : r_pcnt + 1'b1;
      r_frame_pulse <= w_frame_end;
      if (w_tick) begin
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end

      if (w_frame_end) begin
        r_cur_mode <= w_mode_in;
        r_glyph_sh <= glyphs;
        r_dp_sh    <= dp_mask;
        r_bl_sh    <= blink_mask;

        // Period counting uses the mode in force for the frame just ended;
        // a capture that leaves SCROLL/BLINK overrides any step on this edge.
        if (w_mode_in != MODE_SCROLL) begin
          r_ofs  <= '0;
          r_scnt <= '0;
        end else if (r_cur_mode == MODE_SCROLL) begin
          if (r_scnt == SW'(SCROLL_FRAMES - 1)) begin
            r_scnt <= '0;
            r_ofs  <= (r_ofs == IW'(NUM_DIGITS - 1)) ? '0 : r_ofs + 1'b1;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end

        if (w_mode_in != MODE_BLINK) begin
          r_blink_phase <= 1'b0;
          r_bcnt        <= '0;
        end else if (r_cur_mode == MODE_BLINK) begin
          if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
            r_bcnt        <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
      end

      // Outputs follow idx with one cycle of skew.
      if (r_cur_mode == MODE_OFF) begin
        r_dig <= '1;
        r_seg <= SEG_BLANK;
      end else begin
        r_dig <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg <= w_blank ? SEG_BLANK : {~r_dp_sh[r_idx], w_seg7};
      end
    end
  end

  assign dig         = r_dig;
  assign seg         = r_seg;
  assign frame_pulse = r_frame_pulse;

endmodule

// File: tb/tb_seg_scan_engine.sv
// Directed bench for seg_scan_engine with NUM_DIGITS=8, DIG_TICKS=4,
// SCROLL_FRAMES=2, BLINK_FRAMES=2. One frame = 32 cycles. After a
// frame_pulse is observed, digit slot p is sampled 1+4*p edges later.
module tb_seg_scan_engine;

  localparam int N  = 8;
  localparam int DT = 4;
  localparam int SF = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [6*N-1:0] glyphs;
  logic [N-1:0]  dp_mask;
  logic [N-1:0]  blink_mask;
  logic [N-1:0]  dig;
  logic [7:0]    seg;
  logic          frame_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  seg_scan_engine #(
    .NUM_DIGITS    (N),
    .DIG_TICKS     (DT),
    .SCROLL_FRAMES (SF),
    .BLINK_FRAMES  (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .glyphs      (glyphs),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .dig         (dig),
    .seg         (seg),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_counting_glyphs();
    for (int i = 0; i < N; i++) glyphs[6*i +: 6] = 6'(i);
  endtask

  // Bounded wait for the next frame_pulse; leaves time at #1 after that edge.
  task automatic wait_pulse(input string name);
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      if (frame_pulse === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL %s_timeout: got no frame_pulse, required one within 100 cycles", name);
    else begin
      n_pass++;
      $display("frame_pulse %s at cycle %0d", name, cyc);
    end
  endtask

  task automatic test_reset();
    int  edges = 0;
    bit  lit   = 0;
    bit  got   = 0;
    rst = 1'b1; mode = 2'b01; dp_mask = '0; blink_mask = '0;
    set_counting_glyphs();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dig !== 8'hFF) $display("FAIL reset_dig: got %h required %h", dig, 8'hFF); else n_pass++;
    n_checks++; if (seg !== 8'hFF) $display("FAIL reset_seg: got %h required %h", seg, 8'hFF); else n_pass++;
    n_checks++; if (frame_pulse !== 1'b0) $display("FAIL reset_pulse: got %b required 0", frame_pulse); else n_pass++;
    rst = 1'b0;
    // frame_pulse rises on the 32nd edge after release (visible in cycle 33).
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      edges++;
      if (dig !== 8'hFF || seg !== 8'hFF) lit = 1;
      if (frame_pulse === 1'b1) got = 1;
    end
    n_checks++; if (edges !== 32) $display("FAIL reset_first_pulse: got %0d edges required 32", edges); else n_pass++;
    n_checks++; if (lit !== 1'b0) $display("FAIL reset_dark: got lit=%b required 0", lit); else n_pass++;
  endtask

  // Entered just after the first frame_pulse (STATIC captured there).
  task automatic test_static();
    @(posedge clk); #1;
    n_checks++; if (dig !== 8'hFE) $display("FAIL static_d0_dig: got %h required %h", dig, 8'hFE); else n_pass++;
    n_checks++; if (seg !== 8'hC0) $display("FAIL static_d0_seg: got %h required %h", seg, 8'hC0); else n_pass++;
    n_checks++; if (frame_pulse !== 1'b0) $display("FAIL pulse_width: got %b required 0", frame_pulse); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (dig !== 8'hFD) $display("FAIL static_d1_dig: got %h required %h", dig, 8'hFD); else n_pass++;
    n_checks++; if (seg !== 8'hF9) $display("FAIL static_d1_seg: got %h required %h", seg, 8'hF9); else n_pass++;
    // Request SCROLL mid-frame; the current frame must finish as STATIC.
    mode = 2'b10;
    repeat (24) @(posedge clk); #1;
    n_checks++; if (dig !== 8'h7F) $display("FAIL static_d7_dig: got %h required %h", dig, 8'h7F); else n_pass++;
    n_checks++; if (seg !== 8'hF8) $display("FAIL static_d7_seg: got %h required %h", seg, 8'hF8); else n_pass++;
  endtask

  task automatic test_scroll();
    wait_pulse("scroll_f0");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hC0) $display("FAIL scroll_f0_d0: got %h required %h", seg, 8'hC0); else n_pass++;
    wait_pulse("scroll_f1");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hC0) $display("FAIL scroll_f1_d0: got %h required %h", seg, 8'hC0); else n_pass++;
    wait_pulse("scroll_f2");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hF9) $display("FAIL scroll_f2_d0: got %h required %h", seg, 8'hF9); else n_pass++;
    for (int f = 3; f <= 14; f++) wait_pulse("scroll_fn");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hF8) $display("FAIL scroll_ofs7_d0: got %h required %h", seg, 8'hF8); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (dig !== 8'hFD) $display("FAIL scroll_ofs7_d1_dig: got %h required %h", dig, 8'hFD); else n_pass++;
    n_checks++; if (seg !== 8'hC0) $display("FAIL scroll_ofs7_d1_seg: got %h required %h", seg, 8'hC0); else n_pass++;
    wait_pulse("scroll_f15");
    wait_pulse("scroll_f16");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hC0) $display("FAIL scroll_wrap_d0: got %h required %h", seg, 8'hC0); else n_pass++;
  endtask

  task automatic test_blink();
    logic [7:0] exp_d0 [5];
    exp_d0[0] = 8'hC0; exp_d0[1] = 8'hC0; exp_d0[2] = 8'hFF; exp_d0[3] = 8'hFF; exp_d0[4] = 8'hC0;
    mode = 2'b11; blink_mask = 8'h01;
    for (int g = 0; g < 5; g++) begin
      wait_pulse("blink");
      @(posedge clk); #1;
      n_checks++; if (dig !== 8'hFE) $display("FAIL blink_g%0d_d0_dig: got %h required %h", g, dig, 8'hFE); else n_pass++;
      n_checks++; if (seg !== exp_d0[g]) $display("FAIL blink_g%0d_d0_seg: got %h required %h", g, seg, exp_d0[g]); else n_pass++;
      if (g == 2) begin
        repeat (4) @(posedge clk); #1;
        n_checks++; if (seg !== 8'hF9) $display("FAIL blink_g2_d1_seg: got %h required %h", seg, 8'hF9); else n_pass++;
      end
    end
  endtask

  task automatic test_glyph_dp();
    mode = 2'b01; blink_mask = 8'h01; dp_mask = 8'h01;
    glyphs[5:0] = 6'h3A; glyphs[11:6] = 6'h11; glyphs[17:12] = 6'h15; glyphs[23:18] = 6'h0A;
    wait_pulse("glyph");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'h7F) $display("FAIL glyph_blank_dp: got %h required %h", seg, 8'h7F); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (seg !== 8'h8C) $display("FAIL glyph_P: got %h required %h", seg, 8'h8C); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (seg !== 8'hAB) $display("FAIL glyph_n: got %h required %h", seg, 8'hAB); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (seg !== 8'h88) $display("FAIL glyph_A: got %h required %h", seg, 8'h88); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int edges = 0;
    bit lit   = 0;
    bit got   = 0;
    set_counting_glyphs(); dp_mask = '0; blink_mask = '0; mode = 2'b10;
    for (int h = 0; h <= 6; h++) wait_pulse("rmid");
    @(posedge clk); #1;
    n_checks++; if (seg !== 8'hB0) $display("FAIL rmid_ofs3_d0: got %h required %h", seg, 8'hB0); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (dig !== 8'hFF) $display("FAIL rmid_dig: got %h required %h", dig, 8'hFF); else n_pass++;
    n_checks++; if (seg !== 8'hFF) $display("FAIL rmid_seg: got %h required %h", seg, 8'hFF); else n_pass++;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      edges++;
      if (dig !== 8'hFF || seg !== 8'hFF) lit = 1;
      if (frame_pulse === 1'b1) got = 1;
    end
    n_checks++; if (edges !== 32) $display("FAIL rmid_first_pulse: got %0d edges required 32", edges); else n_pass++;
    n_checks++; if (lit !== 1'b0) $display("FAIL rmid_dark: got lit=%b required 0", lit); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dig !== 8'hFE) $display("FAIL rmid_after_dig: got %h required %h", dig, 8'hFE); else n_pass++;
    n_checks++; if (seg !== 8'hC0) $display("FAIL rmid_ofs_cleared: got %h required %h", seg, 8'hC0); else n_pass++;
  endtask

  task automatic test_off();
    mode = 2'b00;
    wait_pulse("off");
    repeat (13) @(posedge clk); #1;
    n_checks++; if (dig !== 8'hFF) $display("FAIL off_dig: got %h required %h", dig, 8'hFF); else n_pass++;
    n_checks++; if (seg !== 8'hFF) $display("FAIL off_seg: got %h required %h", seg, 8'hFF); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_scroll();
    test_blink();
    test_glyph_dp();
    test_reset_mid();
    test_off();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
